// File: rtl/extmem_resp_pkg.sv
// Shared FSM state, write-buffer entry type and default sizes for the external-memory responder.
package extmem_resp_pkg;
   localparam int EXTMEM_ADDR_W   = 16;
   localparam int EXTMEM_DATA_W   = 16;
   localparam int EXTMEM_WB_DEPTH = 4;

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

   // Entry fields are sized by the package widths; non-default widths are changed here.
   typedef struct packed {
      logic                     valid;
      logic [EXTMEM_ADDR_W-1:0] addr;
      logic [EXTMEM_DATA_W-1:0] data;
   } wb_entry_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != '1)) ? v + 32'd1 : v;
   endfunction
endpackage

// File: rtl/extmem_wr_buffer.sv
// Circular posted-write FIFO with a parallel newest-match read lookup over all valid entries.
// Push/pop update at the clock edge; head and lookup are combinational; caller never pushes when full.
module extmem_wr_buffer
   import extmem_resp_pkg::*;
#(
   parameter int ADDR_W = EXTMEM_ADDR_W,
   parameter int DATA_W = EXTMEM_DATA_W,
   parameter int DEPTH  = EXTMEM_WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] lkp_addr_i,
   output logic [CNT_W-1:0]  count_o,
   output logic [ADDR_W-1:0] head_addr_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic              lkp_hit_o,
   output logic [DATA_W-1:0] lkp_data_o
);
   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;

   assign count_o     = count_q;
   assign head_addr_o = mem_q[rd_ptr_q].addr;
   assign head_data_o = mem_q[rd_ptr_q].data;

   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_i && !push_i) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Walk oldest to newest so a younger match overrides an older one.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx        = '0;
      lkp_hit_o  = 1'b0;
      lkp_data_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PTR_W'(k);
         if (mem_q[idx].valid && (mem_q[idx].addr == lkp_addr_i)) begin
            lkp_hit_o  = 1'b1;
            lkp_data_o = mem_q[idx].data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (push_i) begin
            mem_q[wr_ptr_q] <= '{valid: 1'b1, addr: push_addr_i, data: push_data_i};
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            mem_q[rd_ptr_q].valid <= 1'b0;
            rd_ptr_q              <= rd_ptr_q + PTR_W'(1);
         end
      end
   end
endmodule

// File: rtl/extmem_responder.sv
// External-memory responder: 1-cycle reads own the SRAM port, writes are posted and forwarded, flush drains.
// req_ready drops while flushing or with the buffer full; define EXTMEM_RESP_STATS_EN for stat_* counters.
module extmem_responder
   import extmem_resp_pkg::*;
#(
   parameter int ADDR_W   = EXTMEM_ADDR_W,
   parameter int DATA_W   = EXTMEM_DATA_W,
   parameter int WB_DEPTH = EXTMEM_WB_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              req_ready,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              sram_cs,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
`ifdef EXTMEM_RESP_STATS_EN
   ,
   output logic [31:0]       stat_rd,
   output logic [31:0]       stat_wr,
   output logic [31:0]       stat_fwd_hit,
   output logic [31:0]       stat_stall
`endif
);
   localparam int CNT_W = $clog2(WB_DEPTH) + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wb_count;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data, lkp_data;
   logic              lkp_hit, wb_empty;
   logic              acc_re, acc_we, pop, push, direct_wr;
   logic              rsp_vld_q, hit_q;
   logic [DATA_W-1:0] fwd_q, hold_q, rsp_dat;

   // Gating with rst keeps the request side and the SRAM strobes quiet for the whole reset.
   assign req_ready = rst && (state_q == RUN) && (wb_count < CNT_W'(WB_DEPTH));
   assign acc_re    = re && req_ready;
   assign acc_we    = we && req_ready;
   assign wb_empty  = (wb_count == '0);
   assign pop       = !acc_re && !wb_empty;
   assign direct_wr = !acc_re && wb_empty && acc_we;
   assign push      = acc_we && !direct_wr;

   assign sram_cs    = acc_re || pop || direct_wr;
   assign sram_we    = pop || direct_wr;
   assign sram_addr  = acc_re ? rd_addr : (pop ? head_addr : wr_addr);
   assign sram_wdata = pop ? head_data : wr_data;

   extmem_wr_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(WB_DEPTH)) u_wb (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_addr_i (wr_addr),
      .push_data_i (wr_data),
      .pop_i       (pop),
      .lkp_addr_i  (rd_addr),
      .count_o     (wb_count),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .lkp_hit_o   (lkp_hit),
      .lkp_data_o  (lkp_data)
   );

   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      case (state_q)
         RUN:     if (flush_req) state_d = FLUSH;
         FLUSH:   if (wb_empty) begin
                     flush_done = 1'b1;
                     state_d    = RUN;
                  end
         default: state_d = RUN;
      endcase
   end

   assign rsp_dat = hit_q ? fwd_q : sram_rdata;
   assign rd_data = rsp_vld_q ? rsp_dat : hold_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         rsp_vld_q <= 1'b0;
         hit_q     <= 1'b0;
         fwd_q     <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         rsp_vld_q <= acc_re;
         if (acc_re) begin
            hit_q <= lkp_hit;
            fwd_q <= lkp_data;
         end
         if (rsp_vld_q) begin
            hold_q <= rsp_dat;
         end
      end
   end

`ifdef EXTMEM_RESP_STATS_EN
   logic [31:0] st_rd_q, st_wr_q, st_fwd_q, st_stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_rd_q    <= '0;
         st_wr_q    <= '0;
         st_fwd_q   <= '0;
         st_stall_q <= '0;
      end else begin
         st_rd_q    <= sat_inc(st_rd_q, acc_re);
         st_wr_q    <= sat_inc(st_wr_q, acc_we);
         st_fwd_q   <= sat_inc(st_fwd_q, acc_re && lkp_hit);
         st_stall_q <= sat_inc(st_stall_q, (we || re) && !req_ready);
      end
   end

   assign stat_rd      = st_rd_q;
   assign stat_wr      = st_wr_q;
   assign stat_fwd_hit = st_fwd_q;
   assign stat_stall   = st_stall_q;
`endif
endmodule
